// File: rtl/clk_div_ratio_ctrl.sv
// Ratio-change control for the integer clock divider: accepts new ratios over
// valid/ready and applies them only at a rising edge of the divided clock.
module clk_div_ratio_ctrl #(
    parameter int RATIO_W       = 8,
    parameter int DEFAULT_RATIO = 1,
    parameter int CNT_W         = 10
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    input  logic [RATIO_W-1:0] i_req_ratio,
    output logic               o_req_ready,
    input  logic               i_div_clk_fb,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_bypass,
    output logic               o_update_done
);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, APPLY} state_t;

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               fb_d1_q, fb_d2_q;

    logic               fb_rise;
    logic               accept;
    logic [RATIO_W-1:0] req_norm;
    logic [CNT_W-1:0]   tmo_lim;

    assign fb_rise     = fb_d1_q & ~fb_d2_q;
    assign o_req_ready = (state_q == IDLE);
    assign accept      = i_req_valid & o_req_ready;
    // 0 and 1 both mean bypass; store a single encoding
    assign req_norm    = (i_req_ratio == '0) ? RATIO_W'(1) : i_req_ratio;
    // One full divided period plus sync latency; covers a stuck feedback clock
    assign tmo_lim     = CNT_W'({ratio_q, 1'b0}) + CNT_W'(2);

    assign o_div_ratio   = ratio_q;
    assign o_bypass      = (ratio_q < RATIO_W'(2));
    assign o_update_done = done_q;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ratio_q   <= RATIO_W'(DEFAULT_RATIO);
            pending_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            fb_d1_q   <= 1'b0;
            fb_d2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ratio_q   <= ratio_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            fb_d1_q   <= i_div_clk_fb;
            fb_d2_q   <= fb_d1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_d = req_norm;
                    if (req_norm == ratio_q) begin
                        done_d = 1'b1;
                    end else if (o_bypass) begin
                        state_d = APPLY;
                    end else begin
                        state_d = WAIT_EDGE;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_EDGE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fb_rise || (cnt_q == tmo_lim)) state_d = APPLY;
            end
            APPLY: begin
                ratio_d = pending_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench for clk_div_ratio_ctrl: bypass, fb-edge, timeout, same-ratio
// and mid-wait reset scenarios with hand-computed expectations.
module tb_clk_div_ratio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_ratio;
    logic       req_ready;
    logic       fb;
    logic [7:0] div_ratio;
    logic       bypass;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_ratio_ctrl #(.RATIO_W(8), .DEFAULT_RATIO(1), .CNT_W(10)) dut (
        .i_ref_clk    (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_ratio  (req_ratio),
        .o_req_ready  (req_ready),
        .i_div_clk_fb (fb),
        .o_div_ratio  (div_ratio),
        .o_bypass     (bypass),
        .o_update_done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to ratio r by whatever path applies; the wait is bounded.
    task automatic setup_ratio(input logic [7:0] r);
        req_valid = 1'b1;
        req_ratio = r;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) step();
        chk("setup_done", done, 1);
        chk("setup_ratio", div_ratio, r);
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_ratio = 8'd0; fb = 1'b0;
        #12;
        chk("rst_ratio", div_ratio, 1);
        chk("rst_bypass", bypass, 1);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        #10 rst_n = 1'b1;
        step();

        // bypass 1 -> 4: applied two edges after accept, no fb needed
        req_valid = 1'b1; req_ratio = 8'd4;
        step();
        req_valid = 1'b0;
        chk("byp_ready_low", req_ready, 0);
        chk("byp_ratio_old", div_ratio, 1);
        chk("byp_done_early", done, 0);
        step();
        chk("byp_ratio_new", div_ratio, 4);
        chk("byp_done", done, 1);
        chk("byp_ready_back", req_ready, 1);
        chk("byp_bypass_off", bypass, 0);
        step();
        chk("byp_done_1cyc", done, 0);

        // 4 -> 7 waits for fb rise; a second request in the window is ignored
        req_valid = 1'b1; req_ratio = 8'd7;
        step();
        req_ratio = 8'd9;
        for (int i = 0; i < 3; i++) begin
            chk("wait_ratio_hold", div_ratio, 4);
            chk("wait_ready_low", req_ready, 0);
            step();
        end
        fb = 1'b1;
        step();
        chk("fb_sync_ratio", div_ratio, 4);
        step();
        chk("fb_apply_ratio", div_ratio, 4);
        chk("fb_apply_done", done, 0);
        req_valid = 1'b0;
        step();
        chk("fb_ratio_new", div_ratio, 7);
        chk("fb_done", done, 1);
        step();
        chk("fb_no_9", div_ratio, 7);
        chk("fb_done_clr", done, 0);
        fb = 1'b0;
        step(); step(); step();

        // 7 -> bypass (0 normalised to 1), then same-ratio 1/0
        setup_ratio(8'd1);
        req_valid = 1'b1; req_ratio = 8'd0;
        step();
        req_valid = 1'b0;
        chk("same0_done", done, 1);
        chk("same0_ratio", div_ratio, 1);
        chk("same0_ready", req_ready, 1);
        step();
        chk("same0_done_clr", done, 0);

        // 1 -> 6 via bypass, then 6 -> 3 with fb stuck low: timeout at 14
        setup_ratio(8'd6);
        req_valid = 1'b1; req_ratio = 8'd3;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("tmo_hold", div_ratio, 6);
        end
        step();
        chk("tmo_ratio_new", div_ratio, 3);
        chk("tmo_done", done, 1);
        step();

        // same ratio 5 -> 5, back-to-back accepts
        setup_ratio(8'd1);
        setup_ratio(8'd5);
        req_valid = 1'b1; req_ratio = 8'd5;
        step();
        chk("same5_done", done, 1);
        chk("same5_ratio", div_ratio, 5);
        step();
        req_valid = 1'b0;
        chk("same5_b2b_done", done, 1);
        step();
        chk("same5_done_clr", done, 0);

        // 5 -> 4 by timeout, then reset while waiting on 4 -> 9
        setup_ratio(8'd4);
        req_valid = 1'b1; req_ratio = 8'd9;
        step();
        req_valid = 1'b0;
        step(); step(); step();
        chk("rstw_ratio_hold", div_ratio, 4);
        rst_n = 1'b0;
        #2;
        chk("rstw_ratio", div_ratio, 1);
        chk("rstw_ready", req_ready, 1);
        chk("rstw_done", done, 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rstw_no_9", div_ratio, 1);
        end
        chk("rstw_done_end", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
